// File: rtl/gcd_pkg.sv
// Shared GCD result geometry and serializer state encodings, common to the
// serializer, the AXI unpacker and the register file.
package gcd_pkg;

    localparam int RES_W         = 1284;
    localparam int BEAT_W        = 64;
    localparam int BEATS_PER_RES = 21;
    localparam int TOTAL_BEATS   = 42;
    localparam int IDX_W         = 6;
    localparam int PAD_W         = BEATS_PER_RES * BEAT_W;
    localparam int SNAP_W        = 2 * PAD_W;

    localparam logic [IDX_W-1:0] LAST_IDX = 6'd41;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

endpackage

// File: rtl/gcd_result_serializer.sv
// Snapshots the two Bezout results on DONE and drains them as 64-bit
// valid/ready beats, A then B, least-significant word first.
module gcd_result_serializer
    import gcd_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CLKEN,
    input  logic              DONE,
    input  logic [RES_W-1:0]  BEZOUT_A,
    input  logic [RES_W-1:0]  BEZOUT_B,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [BEAT_W-1:0] OUT_DATA,
    output logic              OUT_LAST,
    output logic [IDX_W-1:0]  OUT_IDX,
    output logic              BUSY,
    output logic              OVERRUN,
    input  logic              CLR_OVR
);

    logic [0:0]        state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [SNAP_W-1:0] snap_r;
    logic [BEAT_W-1:0] data_r;
    logic              last_r;
    logic              ovr_r;

    logic              hs_s;
    logic              final_s;
    logic              capture_s;
    logic              ovr_set_s;
    logic [IDX_W-1:0]  idx_next_s;
    logic [SNAP_W-1:0] snap_next_s;

    // The {idx, 6'b0} offset relies on BEAT_W being 64.
    function automatic logic [BEAT_W-1:0] beat_sel(input logic [SNAP_W-1:0] snap,
                                                   input logic [IDX_W-1:0]  idx);
        logic [11:0] base;
        base = {idx, 6'b000000};
        return snap[base +: BEAT_W];
    endfunction

    // Handshake, capture and overrun qualification for this edge.
    always_comb begin
        hs_s        = CLKEN & (state_r == ST_STREAM) & OUT_READY;
        final_s     = hs_s & (idx_r == LAST_IDX);
        capture_s   = CLKEN & DONE & ((state_r == ST_IDLE) | final_s);
        ovr_set_s   = CLKEN & DONE & (state_r == ST_STREAM) & ~final_s;
        idx_next_s  = idx_r + 6'd1;
        snap_next_s = {{(PAD_W-RES_W){1'b0}}, BEZOUT_B,
                       {(PAD_W-RES_W){1'b0}}, BEZOUT_A};
    end

    // FSM, beat index, registered beat payload and sticky overrun.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
            idx_r   <= 6'd0;
            data_r  <= 64'd0;
            last_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else if (CLKEN) begin
            if (capture_s) begin
                state_r <= ST_STREAM;
                idx_r   <= 6'd0;
                data_r  <= BEZOUT_A[BEAT_W-1:0];
                last_r  <= 1'b0;
            end else if (final_s) begin
                state_r <= ST_IDLE;
                idx_r   <= 6'd0;
                data_r  <= 64'd0;
                last_r  <= 1'b0;
            end else if (hs_s) begin
                idx_r   <= idx_next_s;
                data_r  <= beat_sel(snap_r, idx_next_s);
                last_r  <= (idx_next_s == LAST_IDX);
            end
            // A fresh overrun beats a simultaneous clear.
            if (ovr_set_s) begin
                ovr_r <= 1'b1;
            end else if (CLR_OVR) begin
                ovr_r <= 1'b0;
            end
        end
    end

    // Snapshot needs no reset: it is only observed while streaming.
    always_ff @(posedge CLK) begin
        if (capture_s) begin
            snap_r <= snap_next_s;
        end
    end

    assign OUT_VALID = (state_r == ST_STREAM);
    assign BUSY      = (state_r == ST_STREAM);
    assign OUT_DATA  = data_r;
    assign OUT_LAST  = last_r;
    assign OUT_IDX   = idx_r;
    assign OVERRUN   = ovr_r;

endmodule

// File: tb/tb_gcd_result_serializer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and
// compares them on every handshake and checks payload stability during stalls.
module tb_gcd_result_serializer;
    import gcd_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET, CLKEN, DONE, OUT_READY, CLR_OVR;
    logic [RES_W-1:0]  BEZOUT_A, BEZOUT_B;
    logic              OUT_VALID, OUT_LAST, BUSY, OVERRUN;
    logic [BEAT_W-1:0] OUT_DATA;
    logic [IDX_W-1:0]  OUT_IDX;

    typedef struct packed {
        logic [63:0] data;
        logic [5:0]  idx;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       e;
    int          checks = 0;
    int          failures = 0;
    int          hs_cnt = 0;
    logic        stalled = 1'b0;
    logic [63:0] prev_data;
    logic [5:0]  prev_idx;
    logic        prev_last;
    logic [RES_W-1:0] a_v, b_v;

    gcd_result_serializer dut (
        .CLK(CLK), .RESET(RESET), .CLKEN(CLKEN), .DONE(DONE),
        .BEZOUT_A(BEZOUT_A), .BEZOUT_B(BEZOUT_B),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .OUT_LAST(OUT_LAST), .OUT_IDX(OUT_IDX), .BUSY(BUSY),
        .OVERRUN(OVERRUN), .CLR_OVR(CLR_OVR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [RES_W-1:0] gen_vec(input logic [63:0] w0, input logic [31:0] salt);
        logic [1343:0] t;
        t = '0;
        t[63:0] = w0;
        for (int k = 1; k < 21; k++) t[64*k +: 64] = {salt | 32'(k), 32'hC0DE_0000 | 32'(k)};
        return t[RES_W-1:0];
    endfunction

    function automatic logic [63:0] exp_word(input logic [RES_W-1:0] a, input logic [RES_W-1:0] b,
                                             input int k);
        logic [63:0] w;
        for (int j = 0; j < 64; j++) begin
            int pos;
            pos = 64 * (k % 21) + j;
            if (pos < RES_W) w[j] = (k < 21) ? a[pos] : b[pos];
            else             w[j] = 1'b0;
        end
        return w;
    endfunction

    task automatic push_result(input logic [RES_W-1:0] a, input logic [RES_W-1:0] b);
        beat_t x;
        for (int k = 0; k < 42; k++) begin
            x.data = exp_word(a, b, k);
            x.idx  = 6'(k);
            x.last = (k == 41);
            exp_q.push_back(x);
        end
    endtask

    task automatic start(input logic [RES_W-1:0] a, input logic [RES_W-1:0] b);
        BEZOUT_A = a;
        BEZOUT_B = b;
        DONE = 1'b1;
        push_result(a, b);
        tick();
        DONE = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (BUSY && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(BUSY), 64'd0);
    endtask

    // Monitor: handshake scoreboard plus hold checks while stalled.
    always @(negedge CLK) begin
        if (RESET || !OUT_VALID) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_data", OUT_DATA, prev_data);
                chk("hold_idx", 64'(OUT_IDX), 64'(prev_idx));
                chk("hold_last", 64'(OUT_LAST), 64'(prev_last));
            end
            if (OUT_READY && CLKEN) begin
                hs_cnt++;
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat actual_idx=%0d expected=no_beat", OUT_IDX);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", OUT_DATA, e.data);
                    chk("beat_idx", 64'(OUT_IDX), 64'(e.idx));
                    chk("beat_last", 64'(OUT_LAST), 64'(e.last));
                end
            end else begin
                stalled   = 1'b1;
                prev_data = OUT_DATA;
                prev_idx  = OUT_IDX;
                prev_last = OUT_LAST;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; CLKEN = 1'b1; DONE = 1'b0; OUT_READY = 1'b0; CLR_OVR = 1'b0;
        BEZOUT_A = '0; BEZOUT_B = '0;
        repeat (2) tick();
        chk("rst_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_last", 64'(OUT_LAST), 64'd0);
        chk("rst_idx", 64'(OUT_IDX), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_ovr", 64'(OVERRUN), 64'd0);
        chk("rst_data", OUT_DATA, 64'd0);
        RESET = 1'b0;
        tick();

        // A=1, B=2^1283 at full throughput
        hs_cnt = 0;
        OUT_READY = 1'b1;
        a_v = '0; a_v[0] = 1'b1;
        b_v = '0; b_v[RES_W-1] = 1'b1;
        start(a_v, b_v);
        chk("t1_latency_valid", 64'(OUT_VALID), 64'd1);
        chk("t1_beat0", OUT_DATA, 64'h1);
        repeat (41) tick();
        chk("t1_idx41", 64'(OUT_IDX), 64'd41);
        chk("t1_last", 64'(OUT_LAST), 64'd1);
        chk("t1_beat41", OUT_DATA, 64'h8);
        chk("t1_busy_before", 64'(BUSY), 64'd1);
        tick();
        chk("t1_busy_after", 64'(BUSY), 64'd0);
        chk("t1_valid_after", 64'(OUT_VALID), 64'd0);
        chk("t1_hs_count", 64'(hs_cnt), 64'd42);

        // backpressure pattern 1,0,0 repeating
        hs_cnt = 0;
        start(gen_vec(64'hDEADBEEF_CAFEF00D, 32'h1111_0000), gen_vec(64'h0F0F_0F0F_F0F0_F0F0, 32'h2222_0000));
        chk("t2_beat0", OUT_DATA, 64'hDEADBEEF_CAFEF00D);
        for (int c = 0; c < 200 && BUSY; c++) begin
            OUT_READY = (c % 3 == 0);
            tick();
        end
        chk("t2_done", 64'(BUSY), 64'd0);
        chk("t2_hs_count", 64'(hs_cnt), 64'd42);

        // CLKEN low for five cycles mid-stream
        hs_cnt = 0;
        OUT_READY = 1'b1;
        start(gen_vec(64'h5555_AAAA_5555_AAAA, 32'h3333_0000), gen_vec(64'h1234_5678_9ABC_DEF0, 32'h4444_0000));
        repeat (12) tick();
        chk("t3_idx12", 64'(OUT_IDX), 64'd12);
        CLKEN = 1'b0;
        repeat (5) begin
            tick();
            chk("t3_frozen_idx", 64'(OUT_IDX), 64'd12);
        end
        chk("t3_hs_frozen", 64'(hs_cnt), 64'd12);
        CLKEN = 1'b1;
        drain(60);
        chk("t3_hs_count", 64'(hs_cnt), 64'd42);

        // overrun while streaming, clear, then clear racing a new overrun
        start(gen_vec(64'h0000_0000_0000_00A4, 32'h5555_0000), gen_vec(64'h0000_0000_0000_00B4, 32'h6666_0000));
        repeat (10) tick();
        chk("t4_idx10", 64'(OUT_IDX), 64'd10);
        BEZOUT_A = gen_vec(64'hBAD0_BAD0_BAD0_BAD0, 32'h7777_0000);
        BEZOUT_B = gen_vec(64'hBAD1_BAD1_BAD1_BAD1, 32'h8888_0000);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        chk("t4_ovr_set", 64'(OVERRUN), 64'd1);
        chk("t4_idx_continues", 64'(OUT_IDX), 64'd11);
        repeat (3) tick();
        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        chk("t4_ovr_cleared", 64'(OVERRUN), 64'd0);
        repeat (2) tick();
        CLR_OVR = 1'b1;
        DONE = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        DONE = 1'b0;
        chk("t4_set_wins", 64'(OVERRUN), 64'd1);
        drain(60);
        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        chk("t4_ovr_idle_clear", 64'(OVERRUN), 64'd0);

        // DONE coincident with the final handshake
        start(gen_vec(64'h0000_0000_0000_00C5, 32'h9999_0000), gen_vec(64'h0000_0000_0000_00D5, 32'hAAAA_0000));
        repeat (41) tick();
        chk("t5_idx41", 64'(OUT_IDX), 64'd41);
        a_v = gen_vec(64'h0123_4567_89AB_CDEF, 32'hBBBB_0000);
        b_v = gen_vec(64'hFEDC_BA98_7654_3210, 32'hCCCC_0000);
        start(a_v, b_v);
        chk("t5_no_bubble", 64'(OUT_VALID), 64'd1);
        chk("t5_idx0", 64'(OUT_IDX), 64'd0);
        chk("t5_new_beat0", OUT_DATA, 64'h0123_4567_89AB_CDEF);
        chk("t5_no_ovr", 64'(OVERRUN), 64'd0);
        drain(60);

        // DONE held for two ticks from IDLE: second is an overrun
        a_v = gen_vec(64'h0000_0000_0000_00E6, 32'hDDDD_0000);
        b_v = gen_vec(64'h0000_0000_0000_00F6, 32'hEEEE_0000);
        start(a_v, b_v);
        BEZOUT_A = gen_vec(64'hBAD2_BAD2_BAD2_BAD2, 32'h1212_0000);
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        chk("t6_ovr", 64'(OVERRUN), 64'd1);
        chk("t6_idx1", 64'(OUT_IDX), 64'd1);
        drain(60);
        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;

        // asynchronous reset at idx 30, then restart
        start(gen_vec(64'h0000_0000_0000_0017, 32'h1313_0000), gen_vec(64'h0000_0000_0000_0027, 32'h1414_0000));
        repeat (30) tick();
        chk("t7_idx30", 64'(OUT_IDX), 64'd30);
        RESET = 1'b1;
        #2;
        chk("t7_valid_async", 64'(OUT_VALID), 64'd0);
        chk("t7_busy_async", 64'(BUSY), 64'd0);
        chk("t7_idx_async", 64'(OUT_IDX), 64'd0);
        chk("t7_data_async", OUT_DATA, 64'd0);
        exp_q.delete();
        tick();
        RESET = 1'b0;
        tick();
        start(gen_vec(64'hFEED_FACE_0BAD_F00D, 32'h1515_0000), gen_vec(64'h0000_0000_0000_0037, 32'h1616_0000));
        chk("t7_restart_idx", 64'(OUT_IDX), 64'd0);
        chk("t7_restart_beat0", OUT_DATA, 64'hFEED_FACE_0BAD_F00D);
        drain(60);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
